// File: rtl/down_timer_counter_if.sv
// Control/status bundle for the loadable down-counter: the master side issues
// start/stop commands and observes the count, busy and terminal-count flags.
interface down_timer_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_val;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    modport master (
        output start, stop, load_val, periodic,
        input  count, busy, tc
    );

    modport slave (
        input  start, stop, load_val, periodic,
        output count, busy, tc
    );
endinterface

// File: rtl/down_timer_counter.sv
// Synchronous loadable down-counter/timer with one-shot and auto-reload modes.
// Terminal count is registered and is high whenever RUN shows count==0.
module down_timer_counter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    down_timer_counter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg, mode_next;
    logic             tc_reg, tc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            tc_reg     <= tc_next;
        end
    end

    // Priority: stop beats start beats normal counting.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        if (bus.stop) begin
            state_next = IDLE;
        end else if (bus.start) begin
            count_next  = bus.load_val;
            reload_next = bus.load_val;
            mode_next   = bus.periodic;
            state_next  = RUN;
        end else if (state_reg == RUN) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else if (mode_reg) begin
                count_next = reload_reg;
            end else begin
                state_next = IDLE;
            end
        end
        // Registering the look-ahead keeps tc aligned with the visible busy/count.
        tc_next = (state_next == RUN) && (count_next == '0);
    end

    assign bus.count = count_reg;
    assign bus.busy  = (state_reg == RUN);
    assign bus.tc    = tc_reg;
endmodule
